// File: rtl/mem_arb_pkg.sv
// Shared types and geometry for the SRAM sequencer/arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int MEM_WORDS = 32;
    localparam int MEM_AW    = 5;
    localparam int MEM_DW    = 32;
    localparam int AC_AW     = 4;

    typedef enum logic [3:0] {
        IDLE,
        WB_WR,
        WB_RD,
        WB_RDC,
        AC_WR0,
        AC_WR1,
        AC_RD0,
        AC_RD1,
        AC_RDC,
        DONE
    } state_e;

    typedef enum logic {
        WB = 1'b0,
        AC = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-input round-robin grant between the Wishbone and ASCON requesters.
// Latency: grant is combinational from the requests; last-winner flop updates on the granting edge.
// Backpressure: none here; the caller only consults the grant while idle.
// Ports: req_wb_i/req_ac_i requests, upd_en_i allows the tie history to advance,
//        gnt_vld_o any request present, gnt_o selected owner.
module mem_rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   RST,
    input  logic   req_wb_i,
    input  logic   req_ac_i,
    input  logic   upd_en_i,
    output logic   gnt_vld_o,
    output owner_e gnt_o
);

    owner_e last_q;

    always_comb begin
        gnt_vld_o = req_wb_i | req_ac_i;
        gnt_o     = WB;
        if (req_wb_i && req_ac_i) begin
            // Tie: the side that did not win the previous tie goes first.
            gnt_o = (last_q == WB) ? AC : WB;
        end else if (req_ac_i) begin
            gnt_o = AC;
        end
    end

    // History only matters for ties, so only a tie moves it.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            last_q <= WB;
        end else if (upd_en_i && req_wb_i && req_ac_i) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences single-word Wishbone and two-word ASCON accesses onto one 1R1W SRAM.
// Latency: WB write ack cycle 2, WB read ack 3, AC write ack 3, AC read ack 4 (cycle 0 = grant).
// Backpressure: requests are held until ack; one access in flight, new grant only in IDLE.
// Ports: wb_* Wishbone side (5-bit word addr), ac_* ASCON side (4-bit doubleword index),
//        mem_* direct SRAM write/read port controls, busy = not idle.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 wb_req,
    input  logic                 wb_we,
    input  logic [MEM_AW-1:0]    wb_addr,
    input  logic [MEM_DW-1:0]    wb_wdata,
    output logic                 wb_ack,
    output logic [MEM_DW-1:0]    wb_rdata,
    input  logic                 ac_req,
    input  logic                 ac_we,
    input  logic [AC_AW-1:0]     ac_addr,
    input  logic [2*MEM_DW-1:0]  ac_wdata,
    output logic                 ac_ack,
    output logic [2*MEM_DW-1:0]  ac_rdata,
    output logic                 busy,
    output logic                 mem_csb_w,
    output logic [MEM_AW-1:0]    mem_waddr,
    output logic [MEM_DW-1:0]    mem_wdata,
    output logic                 mem_csb_r,
    output logic [MEM_AW-1:0]    mem_raddr,
    input  logic [MEM_DW-1:0]    mem_rdata
);

    state_e              state_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [2*MEM_DW-1:0] wdata_q;
    logic [MEM_DW-1:0]   wb_rdata_q;
    logic [2*MEM_DW-1:0] ac_rdata_q;
    logic                wb_ack_q;
    logic                ac_ack_q;

    logic   gnt_vld;
    owner_e gnt;
    logic   hi_word;

    mem_rr_arb2 u_rr (
        .clk       (clk),
        .RST       (RST),
        .req_wb_i  (wb_req),
        .req_ac_i  (ac_req),
        .upd_en_i  (state_q == IDLE),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt)
    );

    // Owner and direction are folded into the state encoding, so the
    // granting edge only needs to capture address and write data.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_rdata_q <= '0;
            ac_rdata_q <= '0;
            wb_ack_q   <= 1'b0;
            ac_ack_q   <= 1'b0;
        end else begin
            wb_ack_q <= 1'b0;
            ac_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        if (gnt == AC) begin
                            addr_q  <= {ac_addr, 1'b0};
                            wdata_q <= ac_wdata;
                            state_q <= ac_we ? AC_WR0 : AC_RD0;
                        end else begin
                            addr_q  <= wb_addr;
                            wdata_q <= {{MEM_DW{1'b0}}, wb_wdata};
                            state_q <= wb_we ? WB_WR : WB_RD;
                        end
                    end
                end
                WB_WR: begin
                    state_q  <= DONE;
                    wb_ack_q <= 1'b1;
                end
                WB_RD:  state_q <= WB_RDC;
                WB_RDC: begin
                    wb_rdata_q <= mem_rdata;
                    state_q    <= DONE;
                    wb_ack_q   <= 1'b1;
                end
                AC_WR0: state_q <= AC_WR1;
                AC_WR1: begin
                    state_q  <= DONE;
                    ac_ack_q <= 1'b1;
                end
                AC_RD0: state_q <= AC_RD1;
                AC_RD1: begin
                    // Low-word data returns while the high word is being read.
                    ac_rdata_q[MEM_DW-1:0] <= mem_rdata;
                    state_q                <= AC_RDC;
                end
                AC_RDC: begin
                    ac_rdata_q[2*MEM_DW-1:MEM_DW] <= mem_rdata;
                    state_q                       <= DONE;
                    ac_ack_q                      <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Second half of an ASCON access targets the odd word of the pair.
    assign hi_word = (state_q == AC_WR1) || (state_q == AC_RD1);

    assign mem_csb_w = !((state_q == WB_WR) || (state_q == AC_WR0) || (state_q == AC_WR1));
    assign mem_csb_r = !((state_q == WB_RD) || (state_q == AC_RD0) || (state_q == AC_RD1));
    assign mem_waddr = {addr_q[MEM_AW-1:1], addr_q[0] | hi_word};
    assign mem_raddr = {addr_q[MEM_AW-1:1], addr_q[0] | hi_word};
    assign mem_wdata = hi_word ? wdata_q[2*MEM_DW-1:MEM_DW] : wdata_q[MEM_DW-1:0];

    assign busy     = (state_q != IDLE);
    assign wb_ack   = wb_ack_q;
    assign ac_ack   = ac_ack_q;
    assign wb_rdata = wb_rdata_q;
    assign ac_rdata = ac_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter sharing the 32x32 1R1W SRAM between the Wishbone slave port (single 32-bit accesses) and the ASCON core (64-bit block accesses split into two SRAM words). Sits between both requesters and the SRAM macro and drives the macro's write and read ports directly. Only one SRAM access is issued per cycle, so the two ports never collide.

## Interface
Parameters: none. Geometry is fixed by the SRAM macro and lives in the package.
- clk  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- wb_req  in  1  Wishbone access request; held until wb_ack
- wb_we  in  1  1 = write, 0 = read
- wb_addr  in  5  SRAM word address
- wb_wdata  in  32  write data
- wb_ack  out  1  one-cycle completion pulse
- wb_rdata  out  32  read data, valid while wb_ack = 1
- ac_req  in  1  ASCON access request; held until ac_ack
- ac_we  in  1  1 = write, 0 = read
- ac_addr  in  4  64-bit doubleword index
- ac_wdata  in  64  write data
- ac_ack  out  1  one-cycle completion pulse
- ac_rdata  out  64  read data, valid while ac_ack = 1
- busy  out  1  high whenever state != IDLE
- mem_csb_w  out  1  SRAM write-port chip select, active low
- mem_waddr  out  5  SRAM write address
- mem_wdata  out  32  SRAM write data
- mem_csb_r  out  1  SRAM read-port chip select, active low
- mem_raddr  out  5  SRAM read address
- mem_rdata  in  32  SRAM read data, valid the cycle after the read is issued

## Operation
- FSM states: IDLE, WB_WR, WB_RD, WB_RDC, AC_WR0, AC_WR1, AC_RD0, AC_RD1, AC_RDC, DONE.
- **Grant in IDLE.**
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester other than `last`, then update `last`.
  - The clock edge that grants also latches owner, we, address and write data. Requester inputs are ignored until the next IDLE.
- **Address mapping.**
  - The ASCON low word goes to SRAM address {ac_addr,0} and carries data[31:0].
  - The ASCON high word goes to SRAM address {ac_addr,1} and carries data[63:32].
- **Per-state actions.**
  - WB_WR: write the latched word.
  - WB_RD: issue the read. WB_RDC: capture mem_rdata into wb_rdata.
  - AC_WR0 / AC_WR1: write the low word, then the high word.
  - AC_RD0: issue the low-word read.
  - AC_RD1: issue the high-word read and capture the low word into ac_rdata[31:0].
  - AC_RDC: capture the high word into ac_rdata[63:32].
- **DONE.**
  - Assert ack to the latched owner only.
  - Always return to IDLE; no grant is made in DONE.
- **Requester handshake.** The requester deasserts req at the edge where it samples ack high. A req still high in the following IDLE is treated as a new request.
- **SRAM controls.** mem_csb_w and mem_csb_r are combinational decodes of the state. They are never both low in the same cycle. Address and data outputs come from the latched registers.
- **rdata hold.** rdata registers hold their value until the next read overwrites them.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
  - WB write: write issued in cycle 1, ack in cycle 2.
  - WB read: read issued in cycle 1, capture in cycle 2, ack in cycle 3.
  - AC write: writes in cycles 1 and 2, ack in cycle 3.
  - AC read: reads issued in cycles 1 and 2, ack in cycle 4.
- Back-to-back throughput: a new grant is possible in the IDLE cycle right after DONE.
- Reset values:
  - state = IDLE, last = WB, so ASCON wins the first tie.
  - wb_ack = ac_ack = busy = 0.
  - mem_csb_w = mem_csb_r = 1.
  - wb_rdata, ac_rdata, mem_waddr, mem_wdata, mem_raddr and all latches = 0.
- Reset mid-operation: immediate return to IDLE. A partially completed ASCON write may leave only the low word written; there is no rollback and no ack is issued.

## Structure
- Package `mem_arb_pkg`:
  - state enum and owner enum (WB, AC).
  - constants MEM_WORDS = 32, MEM_AW = 5, MEM_DW = 32, AC_AW = 4.
- Sub-module `mem_rr_arb2`: two-input round-robin grant using the `last` flop, with an update-enable driven from IDLE.
- The FSM, latches and rdata registers live in `mem_arbiter`.

## Test plan
- WB write 0xDEADBEEF to addr 5, then WB read addr 5 → write ack in cycle 2, read ack in cycle 3 with wb_rdata = 0xDEADBEEF.
- AC write 0x0123456789ABCDEF to doubleword 3 → SRAM word 6 = 0x89ABCDEF and word 7 = 0x01234567. A following WB read of addr 7 returns 0x01234567.
- AC read of doubleword 3 → ac_ack in cycle 4 with ac_rdata = 0x0123456789ABCDEF, and csb_r low in cycles 1–2 only.
- Both reqs raised in the same cycle after reset, then repeated → first grant AC, then WB, with acks alternating and never both high.
- Change ac_addr and ac_wdata in cycle 1 of an AC write → the originally latched values are written.
- RST asserted in AC_WR1 → state IDLE, no ac_ack, only the low word written, all outputs at their reset values.
